// File: rtl/mult_unit_if.sv
// Handshake and data bundle between the pipeline controller and the HI/LO multiply unit.
// The controller drives the master side and the multiplier drives the slave side.
interface mult_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b, wr_hi, wr_lo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b, wr_hi, wr_lo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_unit.sv
// Sequential radix-2 shift-add multiplier with architectural HI/LO registers
// for the MIPS mult/multu/mfhi/mflo/mthi/mtlo instructions.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        reset,
    mult_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               neg;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] result;

    // Shift-right accumulator: add into the upper half, then shift the whole product right.
    always_comb begin
        abs_a   = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b   = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_b[0] ? {1'b0, mag_a} : '0);
        result  = neg ? -acc : acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc    <= '0;
                        count  <= CW'(WIDTH);
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        if (bus.wr_hi) hi_q <= bus.wdata;
                        if (bus.wr_lo) lo_q <= bus.wdata;
                    end
                end
                RUN: begin
                    acc   <= {partial, acc[WIDTH-1:1]};
                    mag_b <= mag_b >> 1;
                    count <= count - CW'(1);
                    if (count == CW'(1)) state <= FIX;
                end
                FIX: begin
                    hi_q   <= result[2*WIDTH-1:WIDTH];
                    lo_q   <= result[WIDTH-1:0];
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: fixed vectors, HI/LO write and abort corner cases,
// then back-to-back random multiplies against an arithmetic reference.
module tb_mult_unit;
    localparam int W     = 32;
    localparam int LIMIT = 200;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           sgn;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    mult_unit_if #(.WIDTH(W)) bus ();

    mult_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_product(logic [W-1:0] x, logic [W-1:0] y, bit sgn);
        longint         sx;
        longint         sy;
        logic [2*W-1:0] ux;
        logic [2*W-1:0] uy;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {{W{1'b0}}, x};
        uy = {{W{1'b0}}, y};
        return ux * uy;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
        bus.start     = 1'b1;
        bus.a         = x;
        bus.b         = y;
        bus.is_signed = sgn;
        tick();
        bus.start     = 1'b0;
    endtask

    // Counts busy cycles until done; the optional disturbance pokes start and wr_lo mid-run.
    task automatic wait_done(input bit disturb, output int cyc, output bit timed_out);
        logic [W-1:0] hold_hi;
        logic [W-1:0] hold_lo;
        int           i;
        hold_hi = bus.hi;
        hold_lo = bus.lo;
        cyc = 0;
        i   = 0;
        while (bus.done !== 1'b1 && i < LIMIT) begin
            if (bus.busy === 1'b1) cyc++;
            if (disturb) begin
                case (i)
                    10: begin
                        bus.start = 1'b1;
                        bus.a     = 32'd55;
                        bus.b     = 32'd77;
                    end
                    11: begin
                        bus.start = 1'b0;
                        bus.wr_lo = 1'b1;
                        bus.wdata = 32'h1111_1111;
                    end
                    12: bus.wr_lo = 1'b0;
                    default: ;
                endcase
            end
            if (i == 15) begin
                check("hold_hi", bus.hi, hold_hi);
                check("hold_lo", bus.lo, hold_lo);
            end
            tick();
            i++;
        end
        timed_out = (i >= LIMIT);
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                               input int cyc, input bit timed_out);
        check({name, "_timeout"}, timed_out, 0);
        check({name, "_busy_cycles"}, cyc, W + 1);
        check({name, "_done"}, bus.done, 1);
        check({name, "_busy"}, bus.busy, 0);
        check({name, "_hi"}, bus.hi, exp_hi);
        check({name, "_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        vec_t           vecs[7];
        int             cyc;
        bit             to;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        bit             rs;
        logic [2*W-1:0] exp;

        compared   = 0;
        mismatched = 0;

        vecs[0] = '{32'd7,         32'd6,         1'b0, 32'h0000_0000, 32'h0000_002A};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'hFFFF_FFFD, 32'd5,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
        vecs[5] = '{32'h8000_0000, 32'd1,         1'b1, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[6] = '{32'h8000_0000, 32'd2,         1'b0, 32'h0000_0001, 32'h0000_0000};

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.wr_hi     = 1'b0;
        bus.wr_lo     = 1'b0;
        bus.wdata     = '0;
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_hi", bus.hi, 0);
        check("reset_lo", bus.lo, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] fixed vectors");
        for (int k = 0; k < 7; k++) begin
            applyStimulus(vecs[k].a, vecs[k].b, vecs[k].sgn);
            check($sformatf("vec%0d_busy_after_start", k), bus.busy, 1);
            wait_done(1'b0, cyc, to);
            checkOutput($sformatf("vec%0d", k), vecs[k].exp_hi, vecs[k].exp_lo, cyc, to);
            tick();
            check($sformatf("vec%0d_done_pulse", k), bus.done, 0);
        end

        $display("[TB] mthi / mtlo");
        bus.wr_hi = 1'b1;
        bus.wdata = 32'h1234_5678;
        tick();
        check("mthi_hi", bus.hi, 32'h1234_5678);
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'h9ABC_DEF0;
        tick();
        check("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
        check("mtlo_hi_kept", bus.hi, 32'h1234_5678);
        bus.wr_hi = 1'b1;
        bus.wdata = 32'hCAFE_F00D;
        tick();
        check("mthilo_hi", bus.hi, 32'hCAFE_F00D);
        check("mthilo_lo", bus.lo, 32'hCAFE_F00D);
        bus.wr_lo = 1'b0;

        $display("[TB] start wins over mthi");
        bus.wdata = 32'hDEAD_BEEF;
        applyStimulus(32'd2, 32'd3, 1'b0);
        bus.wr_hi = 1'b0;
        check("start_wins_hi_kept", bus.hi, 32'hCAFE_F00D);
        wait_done(1'b0, cyc, to);
        checkOutput("start_wins", 32'd0, 32'd6, cyc, to);
        tick();

        $display("[TB] start and mtlo ignored while busy");
        applyStimulus(32'd1000, 32'd3, 1'b0);
        wait_done(1'b1, cyc, to);
        checkOutput("ignore_busy", 32'd0, 32'd3000, cyc, to);
        tick();
        check("ignore_busy_no_restart", bus.busy, 0);

        $display("[TB] reset mid-run");
        applyStimulus(32'd5, 32'd5, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        #2 reset = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        #2 reset = 1'b0;
        tick();
        check("abort_stays_idle", bus.busy, 0);
        applyStimulus(32'd2, 32'd3, 1'b0);
        wait_done(1'b0, cyc, to);
        checkOutput("after_reset", 32'd0, 32'd6, cyc, to);

        $display("[TB] back-to-back random");
        ra  = $urandom;
        rb  = $urandom;
        rs  = 1'($urandom_range(0, 1));
        exp = ref_product(ra, rb, rs);
        applyStimulus(ra, rb, rs);
        for (int k = 0; k < 24; k++) begin
            wait_done(1'b0, cyc, to);
            checkOutput($sformatf("rand%0d", k), exp[2*W-1:W], exp[W-1:0], cyc, to);
            if (k < 23) begin
                case (k % 4)
                    0: ra = 32'h8000_0000;
                    1: rb = 32'hFFFF_FFFF;
                    2: ra = '0;
                    default: begin
                        ra = $urandom;
                        rb = $urandom;
                    end
                endcase
                if (k % 4 != 0 && k % 4 != 2) ra = $urandom;
                if (k % 4 != 1) rb = $urandom;
                rs  = 1'($urandom_range(0, 1));
                exp = ref_product(ra, rb, rs);
                applyStimulus(ra, rb, rs);
                check($sformatf("rand%0d_b2b_busy", k), bus.busy, 1);
                check($sformatf("rand%0d_b2b_done", k), bus.done, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mult_unit.md
# mult_unit

Sequential radix-2 shift-add multiplier with architectural HI/LO registers, serving the MIPS `mult`, `multu`, `mfhi`, `mflo`, `mthi` and `mtlo` instructions. It sits beside the ALU in the processor datapath. The controller launches a multiply with `start` and stalls any `mfhi`/`mflo` while `busy` is high. The datapath reads `hi`/`lo` directly.

## Interface
- WIDTH, 32, operand width; the product is 2*WIDTH bits, split into hi/lo.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  launch a multiply of a×b; accepted only when busy=0.
- is_signed  in  1  sampled with start; 1 = `mult` (two's complement), 0 = `multu`.
- a  in  WIDTH  multiplicand, sampled on the accepting edge.
- b  in  WIDTH  multiplier, sampled on the accepting edge.
- wr_hi  in  1  `mthi`: load wdata into hi.
- wr_lo  in  1  `mtlo`: load wdata into lo.
- wdata  in  WIDTH  data for wr_hi/wr_lo.
- busy  out  1  multiply in progress; hi/lo not valid for reading.
- done  out  1  one-cycle pulse: hi/lo hold the new product.
- hi  out  WIDTH  upper half of the product, or the mthi value.
- lo  out  WIDTH  lower half of the product, or the mtlo value.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - Latch mag_a=|a| and mag_b=|b| if is_signed, otherwise the raw operands.
  - Latch neg = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Clear the 2*WIDTH accumulator, set count=WIDTH, busy=1, go to RUN.
- RUN, each cycle:
  - If mag_b[0], add mag_a, shifted left by (WIDTH-count), into the accumulator. A shift-right accumulator formulation is equivalent and permitted.
  - Shift mag_b right, decrement count.
  - When count reaches 0, go to FIX.
- FIX: compute result = neg ? (two's complement of the accumulator) : accumulator. Write hi=result[2W-1:W] and lo=result[W-1:0], pulse done, clear busy, return to IDLE.
- Magnitudes are WIDTH-bit unsigned, so |0x80000000| = 0x80000000 with no overflow. The accumulator and the negation are 2*WIDTH bits wide.
- wr_hi/wr_lo in IDLE with start=0 load wdata on the edge. Both may assert together and load both registers.
- start and wr_hi/wr_lo together in IDLE: start wins and the writes are dropped.
- start, wr_hi and wr_lo while busy are ignored; no queuing.
- hi/lo keep their old values throughout RUN and change only on the FIX edge.
- reset, at any time including mid-RUN: asynchronously returns to IDLE with hi=0, lo=0, busy=0, done=0 and count=0. The in-flight operation is lost.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state IDLE.
- start sampled high on edge E0 → busy=1 after E0.
- RUN iterations occur on E1..E(WIDTH); the state is FIX after E(WIDTH).
- Edge E(WIDTH+1) writes hi/lo, sets busy=0 and done=1. done returns to 0 after E(WIDTH+2).
- busy is high for exactly WIDTH+1 cycles (33 at default width).
- A new start is accepted on E(WIDTH+1)+1 at the earliest, i.e. in the cycle where done=1. Back-to-back operations therefore issue every WIDTH+2 cycles.
- mthi/mtlo latency: 1 edge; the value is visible on hi/lo immediately after.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- multu with a=7, b=6 → after 33 busy cycles hi=0x00000000, lo=0x0000002A, done pulsed once.
- multu with a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- mult with a=-3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- mult with a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
- mult with a=b=0xFFFFFFFF → hi=0, lo=1.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on consecutive cycles → hi/lo show each value one edge after its write.
- Then start multu 2×3 with wr_hi=1 on the same cycle → the write is dropped and the final result is hi=0, lo=6.
- Start a multiply; 10 cycles in, pulse start with new operands, then assert wr_lo → both are ignored and the original product is delivered on schedule.
- Then assert reset mid-RUN of a second multiply → busy=0, done=0, hi=lo=0 immediately, without waiting for a clock edge.
- After reset, a fresh multu 2×3 completes normally with lo=6.
